// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: opcode encodings, FSM state and the flag bundle.
// Used by alu_seq and by its testbench.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_ROL1 = 4'h5;
   localparam logic [3:0] ALU_ROR1 = 4'h6;
   localparam logic [3:0] ALU_CLRB = 4'h7;
   localparam logic [3:0] ALU_SETB = 4'h8;
   localparam logic [3:0] ALU_INC  = 4'h9;
   localparam logic [3:0] ALU_DEC  = 4'hA;
   localparam logic [3:0] ALU_NOT  = 4'hB;
   localparam logic [3:0] ALU_DAAP = 4'hC;
   localparam logic [3:0] ALU_DAAS = 4'hD;
   localparam logic [3:0] ALU_MUL  = 4'hE;
   localparam logic [3:0] ALU_DIV  = 4'hF;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic c;
      logic v;
      logic h;
   } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of alu_seq. The master drives operands and start;
// the slave (the ALU) returns the gated result, the flags and the handshake.
interface alu_seq_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             carryIn;
   logic             halfCarry;
   logic             outputEnable;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             C;
   logic             V;
   logic             H;
   logic             busy;
   logic             done;

   modport master (
      output start, opcode, A, B, carryIn, halfCarry, outputEnable,
      input  result, result_hi, C, V, H, busy, done
   );

   modport slave (
      input  start, opcode, A, B, carryIn, halfCarry, outputEnable,
      output result, result_hi, C, V, H, busy, done
   );

endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-clock engine for unsigned shift-add multiply and restoring divide.
// res_lo/res_hi present the outcome of the current iteration; last marks the final one.
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             run,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             c,
   output logic             v,
   output logic             last
);

   localparam int CNT_W = $clog2(WIDTH);

   // hi_q: accumulator (MUL) / partial remainder (DIV); lo_q: multiplier / dividend-quotient.
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] m_q;
   logic             div_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ok;

   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   // Compare on the full shifted width so a zero divisor still always subtracts.
   assign div_ok    = (div_shift >= {1'b0, m_q});
   assign div_diff  = div_shift[WIDTH-1:0] - m_q;

   assign res_hi = div_q ? (div_ok ? div_diff : div_shift[WIDTH-1:0]) : mul_sum[WIDTH:1];
   assign res_lo = div_q ? {lo_q[WIDTH-2:0], div_ok} : {mul_sum[0], lo_q[WIDTH-1:1]};
   assign last   = (cnt_q == CNT_W'(WIDTH - 1));
   assign c      = ~div_q & (|res_hi);
   assign v      = div_q & ~(|m_q);

   // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (load) begin
         hi_q  <= '0;
         lo_q  <= is_div ? a : b;
         m_q   <= is_div ? b : a;
         div_q <= is_div;
         cnt_q <= '0;
      end else if (run) begin
         hi_q  <= res_hi;
         lo_q  <= res_lo;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Clocked WIDTH-bit ALU: 14 single-cycle ops plus iterative MUL/DIV with start/busy/done.
// Define ALU_MULDIV_EN to build the MUL/DIV engine; otherwise opcodes E/F return zeros.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic      clk,
   input logic      rst_n,
   alu_seq_if.slave bus
);

   localparam int               IDX_W    = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

   logic             accept;
   logic             accept_sc;
   logic             busy;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] hi_q;
   flags_t           flags_q;
   logic             done_q;

   logic [WIDTH-1:0] add_b;
   logic [WIDTH:0]   add_sum;
   logic [4:0]       add_nib;
   logic             add_v;
   logic [WIDTH-1:0] bit_mask;
   logic             daa_adj;
   logic [7:0]       daa_lo;
   logic [7:0]       daa_out;
   logic             daa_c;
   logic [WIDTH-1:0] sc_res;
   flags_t           sc_flags;

   // SUB reuses the adder with B inverted; carryIn then acts as not-borrow.
   assign add_b    = (bus.opcode == ALU_SUB) ? ~bus.B : bus.B;
   assign add_sum  = {1'b0, bus.A} + {1'b0, add_b} + {{WIDTH{1'b0}}, bus.carryIn};
   assign add_nib  = {1'b0, bus.A[3:0]} + {1'b0, add_b[3:0]} + {4'b0, bus.carryIn};
   assign add_v    = ~(bus.A[WIDTH-1] ^ add_b[WIDTH-1]) & (bus.A[WIDTH-1] ^ add_sum[WIDTH-1]);
   assign bit_mask = ONE << bus.B[IDX_W-1:0];
   assign daa_adj  = bus.halfCarry | (bus.A[3:0] > 4'd9);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      sc_res   = '0;
      sc_flags = '0;
      daa_lo   = 8'h00;
      daa_out  = 8'h00;
      daa_c    = 1'b0;
      case (bus.opcode)
         ALU_ADD, ALU_SUB: begin
            sc_res   = add_sum[WIDTH-1:0];
            sc_flags = '{c: add_sum[WIDTH], v: add_v, h: add_nib[4]};
         end
         ALU_AND:  sc_res = bus.A & bus.B;
         ALU_OR:   sc_res = bus.A | bus.B;
         ALU_XOR:  sc_res = bus.A ^ bus.B;
         ALU_NOT:  sc_res = ~bus.A;
         ALU_ROL1: begin
            sc_res     = {bus.A[WIDTH-2:0], bus.carryIn};
            sc_flags.c = bus.A[WIDTH-1];
         end
         ALU_ROR1: begin
            sc_res     = {bus.carryIn, bus.A[WIDTH-1:1]};
            sc_flags.c = bus.A[0];
         end
         ALU_CLRB: sc_res = bus.A & ~bit_mask;
         ALU_SETB: sc_res = bus.A | bit_mask;
         ALU_INC: begin
            sc_res   = bus.A + ONE;
            sc_flags = '{c: &bus.A, v: (bus.A == ~MSB_ONLY), h: &bus.A[3:0]};
         end
         ALU_DEC: begin
            sc_res   = bus.A - ONE;
            sc_flags = '{c: |bus.A, v: (bus.A == MSB_ONLY), h: |bus.A[3:0]};
         end
         ALU_DAAP: begin
            daa_lo     = bus.A[7:0] + (daa_adj ? 8'h06 : 8'h00);
            daa_c      = bus.carryIn | (daa_lo > 8'h99);
            daa_out    = daa_lo + (daa_c ? 8'h60 : 8'h00);
            sc_res     = bus.A;
            sc_res[7:0] = daa_out;
            sc_flags.c = daa_c;
         end
         ALU_DAAS: begin
            daa_lo     = bus.A[7:0] - (daa_adj ? 8'h06 : 8'h00);
            daa_c      = bus.carryIn | (bus.A[7:0] > 8'h99);
            daa_out    = daa_lo - (daa_c ? 8'h60 : 8'h00);
            sc_res     = bus.A;
            sc_res[7:0] = daa_out;
            sc_flags.c = daa_c;
         end
         default: ;
      endcase
   end

`ifdef ALU_MULDIV_EN
   state_t           state;
   state_t           state_next;
   logic             is_muldiv;
   logic             finish;
   logic             it_last;
   logic             it_c;
   logic             it_v;
   logic [WIDTH-1:0] it_lo;
   logic [WIDTH-1:0] it_hi;

   assign is_muldiv = (bus.opcode == ALU_MUL) || (bus.opcode == ALU_DIV);
   assign busy      = (state == RUN);
   assign accept    = bus.start & ~busy;
   assign accept_sc = accept & ~is_muldiv;
   assign finish    = busy & it_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && is_muldiv) state_next = RUN;
         RUN:     if (it_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept & is_muldiv),
      .run    (busy),
      .is_div (bus.opcode == ALU_DIV),
      .a      (bus.A),
      .b      (bus.B),
      .res_lo (it_lo),
      .res_hi (it_hi),
      .c      (it_c),
      .v      (it_v),
      .last   (it_last)
   );
`else
   assign busy      = 1'b0;
   assign accept    = bus.start;
   assign accept_sc = accept;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         hi_q    <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept_sc) begin
            res_q   <= sc_res;
            hi_q    <= '0;
            flags_q <= sc_flags;
            done_q  <= 1'b1;
         end
`ifdef ALU_MULDIV_EN
         else if (finish) begin
            res_q   <= it_lo;
            hi_q    <= it_hi;
            flags_q <= '{c: it_c, v: it_v, h: 1'b0};
            done_q  <= 1'b1;
         end
`endif
      end
   end

   assign bus.result    = bus.outputEnable ? res_q : '0;
   assign bus.result_hi = bus.outputEnable ? hi_q : '0;
   assign bus.C         = flags_q.c;
   assign bus.V         = flags_q.v;
   assign bus.H         = flags_q.h;
   assign bus.busy      = busy;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expectations go into a scoreboard queue at issue
// and are popped when done rises. Expected MUL/DIV values follow ALU_MULDIV_EN.
module tb_alu_seq;
   import alu_pkg::*;

`ifdef ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [7:0] res;
      logic [7:0] hi;
      logic       c;
      logic       v;
      logic       h;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   errors = 0;
   int   checks = 0;
   bit   seen_done;
   exp_t sb[$];

   alu_seq_if #(.WIDTH(8))  bus ();
   alu_seq_if #(.WIDTH(16)) bus16 ();

   alu_seq #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input string tag, input logic [7:0] res, input logic [7:0] hi,
                               input logic c, input logic v, input logic h, input int lat);
      exp_t e;
      e.tag = tag;
      e.res = res;
      e.hi  = hi;
      e.c   = c;
      e.v   = v;
      e.h   = h;
      e.lat = lat;
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic hcin, input exp_t e);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.opcode    = op;
      bus.A         = a;
      bus.B         = b;
      bus.carryIn   = cin;
      bus.halfCarry = hcin;
      sb.push_back(e);
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      bus.start = 1'b0;
      check({e.tag, ".busy_at_accept"}, bus.busy, e.lat != 0);
   endtask

   task automatic await_done(input bit gap);
      exp_t e;
      while (bus.done !== 1'b1 && (cyc - acc_cyc) < 40) begin
         @(posedge clk);
         #1;
      end
      e = sb.pop_front();
      check({e.tag, ".latency"}, cyc - acc_cyc, e.lat);
      check({e.tag, ".result"},  bus.result,    e.res);
      check({e.tag, ".hi"},      bus.result_hi, e.hi);
      check({e.tag, ".C"},       bus.C,         e.c);
      check({e.tag, ".V"},       bus.V,         e.v);
      check({e.tag, ".H"},       bus.H,         e.h);
      check({e.tag, ".busy_at_done"}, bus.busy, 1'b0);
      if (gap) begin
         @(posedge clk);
         #1;
         check({e.tag, ".done_one_cycle"}, bus.done, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;   bus.opcode = 4'h0;  bus.A = '0;   bus.B = '0;
      bus.carryIn = 1'b0; bus.halfCarry = 1'b0; bus.outputEnable = 1'b1;
      bus16.start = 1'b0;   bus16.opcode = 4'h0;  bus16.A = '0;   bus16.B = '0;
      bus16.carryIn = 1'b0; bus16.halfCarry = 1'b0; bus16.outputEnable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.result", bus.result,    8'h00);
      check("rst.hi",     bus.result_hi, 8'h00);
      check("rst.C",      bus.C,    1'b0);
      check("rst.V",      bus.V,    1'b0);
      check("rst.H",      bus.H,    1'b0);
      check("rst.busy",   bus.busy, 1'b0);
      check("rst.done",   bus.done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-cycle ops: {C,V,H} order in mk is c, v, h.
      issue(ALU_ADD,  8'hFF, 8'h01, 1'b0, 1'b0, mk("add_ff_01", 8'h00, 8'h00, 1, 0, 1, 0)); await_done(1);
      issue(ALU_SUB,  8'h80, 8'h01, 1'b1, 1'b0, mk("sub_80_01", 8'h7F, 8'h00, 1, 1, 0, 0)); await_done(1);
      issue(ALU_DEC,  8'h00, 8'h00, 1'b0, 1'b0, mk("dec_00",    8'hFF, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_INC,  8'hFF, 8'h00, 1'b0, 1'b0, mk("inc_ff",    8'h00, 8'h00, 1, 0, 1, 0)); await_done(1);
      issue(ALU_AND,  8'hA5, 8'h0F, 1'b1, 1'b0, mk("and",       8'h05, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_OR,   8'h0F, 8'hF0, 1'b0, 1'b0, mk("or",        8'hFF, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_XOR,  8'hA5, 8'hFF, 1'b0, 1'b0, mk("xor",       8'h5A, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_NOT,  8'h0F, 8'h00, 1'b0, 1'b0, mk("not",       8'hF0, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_ROL1, 8'h81, 8'h00, 1'b0, 1'b0, mk("rol1",      8'h02, 8'h00, 1, 0, 0, 0)); await_done(1);
      issue(ALU_ROR1, 8'h01, 8'h00, 1'b1, 1'b0, mk("ror1",      8'h80, 8'h00, 1, 0, 0, 0)); await_done(1);
      issue(ALU_SETB, 8'h00, 8'h07, 1'b0, 1'b0, mk("setb7",     8'h80, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_CLRB, 8'hFF, 8'h03, 1'b0, 1'b0, mk("clrb3",     8'hF7, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_DAAP, 8'h0A, 8'h00, 1'b0, 1'b1, mk("daap_0a",   8'h10, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_DAAP, 8'h22, 8'h00, 1'b0, 1'b1, mk("daap_22",   8'h28, 8'h00, 0, 0, 0, 0)); await_done(1);
      issue(ALU_DAAS, 8'h0F, 8'h00, 1'b1, 1'b1, mk("daas_0f",   8'hA9, 8'h00, 1, 0, 0, 0)); await_done(1);

      // MUL 0F*11; with the engine built, a start three cycles in must be dropped.
      issue(ALU_MUL, 8'h0F, 8'h11, 1'b0, 1'b0,
            mk("mul_0f_11", MD ? 8'hFF : 8'h00, 8'h00, 0, 0, 0, MD ? 8 : 0));
`ifdef ALU_MULDIV_EN
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = ALU_ADD; bus.A = 8'h01; bus.B = 8'h01;
      @(posedge clk);
      #1;
      check("ignored_start.busy", bus.busy, 1'b1);
      bus.start = 1'b0;
`endif
      await_done(1);

      issue(ALU_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0,
            mk("mul_ff_ff", MD ? 8'h01 : 8'h00, MD ? 8'hFE : 8'h00, MD, 0, 0, MD ? 8 : 0));
      await_done(1);

      // Output gating is combinational; flags are not gated.
      bus.outputEnable = 1'b0;
      #1;
      check("oe_low.result", bus.result,    8'h00);
      check("oe_low.hi",     bus.result_hi, 8'h00);
      check("oe_low.C",      bus.C,         MD);
      bus.outputEnable = 1'b1;
      #1;
      check("oe_high.hi",    bus.result_hi, MD ? 8'hFE : 8'h00);

      // DIV pair issued back-to-back: the second start lands in the done cycle.
      issue(ALU_DIV, 8'h64, 8'h07, 1'b0, 1'b0,
            mk("div_64_07", MD ? 8'h0E : 8'h00, MD ? 8'h02 : 8'h00, 0, 0, 0, MD ? 8 : 0));
      await_done(0);
      issue(ALU_DIV, 8'h64, 8'h00, 1'b0, 1'b0,
            mk("div_64_00", MD ? 8'hFF : 8'h00, MD ? 8'h64 : 8'h00, 0, MD, 0, MD ? 8 : 0));
      await_done(1);

`ifdef ALU_MULDIV_EN
      // Reset mid-MUL: outputs clear at once and the aborted op never signals done.
      issue(ALU_MUL, 8'h0F, 8'h11, 1'b0, 1'b0, mk("mul_abort", 8'hFF, 8'h00, 0, 0, 0, 8));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort.result", bus.result,    8'h00);
      check("abort.hi",     bus.result_hi, 8'h00);
      check("abort.V",      bus.V,    1'b0);
      check("abort.busy",   bus.busy, 1'b0);
      check("abort.done",   bus.done, 1'b0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.done) seen_done = 1'b1;
      end
      check("abort.no_done", seen_done, 1'b0);
`endif

      // Wide instance: carry out of the full 16-bit adder.
      @(negedge clk);
      bus16.start = 1'b1; bus16.opcode = ALU_ADD; bus16.A = 16'hFFFF; bus16.B = 16'h0001;
      bus16.carryIn = 1'b0;
      @(posedge clk);
      #1;
      bus16.start = 1'b0;
      check("add16.done",   bus16.done,      1'b1);
      check("add16.result", bus16.result,    16'h0000);
      check("add16.hi",     bus16.result_hi, 16'h0000);
      check("add16.C",      bus16.C,         1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the CTI-8 combinational ALU. Keeps the existing 14-operation set and flag semantics, generalised to `WIDTH` bits, and adds iterative unsigned multiply and divide. Uses a start/busy/done handshake and registered outputs. Sits between the register file and the flag/accumulator write-back path of the wider-datapath core.

## Interface
- `WIDTH`, 8: operand/result width. Must be ≥ 8.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request; sampled only when `busy`=0.
- `opcode` in 4: operation, 0x0–0xF.
- `A`, `B` in WIDTH: operands, latched on accept.
- `carryIn` in 1: carry / not-borrow input, latched on accept.
- `halfCarry` in 1: half-carry input for DAA, latched on accept.
- `outputEnable` in 1: combinational gate on `result` and `result_hi`; when low, both read 0 and flags are unaffected.
- `result` out WIDTH: low result, registered.
- `result_hi` out WIDTH: MUL high half / DIV remainder; 0 for all other ops.
- `C`, `V`, `H` out 1: registered flags.
- `busy` out 1: a multi-cycle op is in progress.
- `done` out 1: one-cycle pulse when `result` and flags update.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ROL1, 6 ROR1, 7 CLRB, 8 SETB, 9 INC, A DEC, B NOT, C DAAP, D DAAS, E MUL, F DIV.
- ADD:
  - `{C,r} = A+B+cin`.
  - `H` = carry out of bit 3.
  - `V = ~(A^B)[msb] & (A^r)[msb]`.
- SUB:
  - `A + ~B + cin`; `cin`=1 means no borrow.
  - `C` = carry out; `H` = bit-3 carry of `A + ~B + cin`.
  - `V = (A^B)[msb] & (A^r)[msb]`.
- AND/OR/XOR/NOT: `C`=`V`=`H`=0.
- ROL1: `r={A[W-2:0],cin}`, `C=A[msb]`.
- ROR1: `r={cin,A[W-1:1]}`, `C=A[0]`.
- CLRB/SETB: bit index is `B[$clog2(WIDTH)-1:0]`; flags 0.
- INC:
  - `C=(A==all-ones)`, `H=(A[3:0]==F)`, `V=(A==0111…1)`.
- DEC:
  - `C=(A!=0)`, `H=(A[3:0]!=0)`, `V=(A==1000…0)`.
- DAAP/DAAS:
  - Operate on `A[7:0]` only; upper bits pass through unchanged. `H`=0.
  - DAAP: add 0x06 if `hcin` or low nibble >9. Then add 0x60 and set `C` if `cin` or the intermediate byte >0x99; otherwise `C`=`cin`.
  - DAAS: subtract 0x06 if `hcin` or low nibble >9. Then subtract 0x60 and set `C` if `cin` or the original byte >0x99.
- MUL (unsigned shift-add):
  - `{result_hi,result} = A*B`.
  - `C = (result_hi!=0)`, `V`=`H`=0.
- DIV (unsigned restoring):
  - `result`=quotient, `result_hi`=remainder, `C`=`V`=`H`=0.
  - `B`=0: `result`=all-ones, `result_hi`=`A`, `V`=1.
- `result_hi` is 0 for ops 0x0–0xD.
- Outputs hold their value until the next `done`.

## Timing
- Reset: `result`, `result_hi`, `C`, `V`, `H`, `busy`, `done` all 0; the iteration counter clears.
- Accept: `start`=1 and `busy`=0 at edge N.
- Ops 0x0–0xD:
  - Outputs update at edge N.
  - `done`=1 for the cycle after edge N; `busy` stays 0.
- MUL/DIV:
  - FSM IDLE→RUN at edge N; `busy`=1 from edge N.
  - `WIDTH` iterations, one per edge.
  - At edge N+WIDTH: outputs update, `busy`→0, `done`=1 for one cycle, RUN→IDLE.
- `start` while `busy`=1 is ignored and not queued.
- Back-to-back: `start` may be asserted in the `done` cycle.
- `rst_n` low mid-operation aborts immediately. All outputs go to reset values; no `done`.
- `outputEnable` has no latency.

## Configuration
- `ALU_MULDIV_EN` defined:
  - MUL/DIV datapath and RUN state are built.
- `ALU_MULDIV_EN` undefined:
  - Opcodes E/F complete single-cycle with `result`=`result_hi`=0, flags 0, `done` pulse.
  - `busy` is tied to 0.

## Structure
- `alu_pkg`: opcode localparams `ALU_ADD`…`ALU_DIV`, and FSM state enum (IDLE, RUN).
- Sub-module `alu_muldiv_iter`: shift-add / restoring-divide iteration with its counter. Instantiated only under `ALU_MULDIV_EN`.
- Single-cycle ops: combinational logic in the top, feeding the output registers.

## Test plan
- WIDTH=8, ADD `FF+01`, cin 0 → `result` 00, C1 H1 V0, `done` one cycle after accept, `busy` never high.
- SUB `80-01`, cin 1 → 7F, C1 V1 H0. DEC `00` → FF, C0 H0 V0. INC `FF` → 00, C1 H1.
- MUL `0F*11` → `result` FF, `result_hi` 00, C0; `done` 8 cycles after accept. A `start` at cycle 3 is ignored. Then MUL `FF*FF` → FE01, C1.
- DIV `64/07` → 0E rem 02. DIV `64/00` → FF, `result_hi` 64, V1.
- DAAP `0A` with hcin 1 → 10, C0. DAAP `22` with hcin 1 → 28. DAAS `0F` with cin 1, hcin 1 → A9, C1.
- Reset mid-MUL at cycle 4 → all outputs 0, `busy` 0, no `done`. WIDTH=16 ADD `FFFF+0001` → 0000, C1. Without `ALU_MULDIV_EN`, MUL → 0 with a single-cycle `done`.
